// File: rtl/regfile_sb.sv
// Multi-ported register file with per-register busy scoreboard.
// Each read port resolves bypass, array read and busy status in its own instance.

module regfile_sb_rdport #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]                rs,
    input  logic [NREG-1:0][XLEN-1:0]    regs,
    input  logic [NREG-1:0]              busy,
    input  logic                         byp_en,
    input  logic [NWR-1:0]               we,
    input  logic [NWR-1:0][AW-1:0]       wa,
    input  logic [NWR-1:0][XLEN-1:0]     wd,
    output logic [XLEN-1:0]              rdata,
    output logic                         rbusy
);
    logic            hit;
    logic [XLEN-1:0] hdata;

    // Ascending scan so the highest-indexed matching write port forwards.
    always_comb begin
        hit   = 1'b0;
        hdata = '0;
        for (int j = 0; j < NWR; j++) begin
            if (byp_en && we[j] && (wa[j] == rs) && (rs != '0)) begin
                hit   = 1'b1;
                hdata = wd[j];
            end
        end
        rdata = hit ? hdata : regs[rs];
        rbusy = ~hit & busy[rs];
    end
endmodule

module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NRD*AW-1:0]    rs_addr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_stall,
    input  logic                 flush
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy, busy_nxt;
    logic [NRD-1:0][AW-1:0]    ra;
    logic [NWR-1:0][AW-1:0]    wa;
    logic [NWR-1:0][XLEN-1:0]  wd;
    logic                      issue_acc;
    logic                      byp_en;

    assign ra = rs_addr;
    assign wa = waddr;
    assign wd = wdata;

    assign issue_stall = issue_valid & busy[issue_rd] & (issue_rd != '0) & ~flush;
    assign issue_acc   = issue_valid & ~issue_stall & ~flush & (issue_rd != '0);
    // Forwarding is suppressed while in reset so every read port shows zero.
    assign byp_en      = (BYPASS != 0) & nRST;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (we[j] && (wa[j] != '0))
                    regs[wa[j]] <= wd[j];
        end
    end

    // Clear on write, then set on issue (set wins), then flush overrides all.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++)
            if (we[j] && (wa[j] != '0))
                busy_nxt[wa[j]] = 1'b0;
        if (issue_acc)
            busy_nxt[issue_rd] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_sb_rdport #(
            .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .AW(AW)
        ) u_rd (
            .rs     (ra[i]),
            .regs   (regs),
            .busy   (busy),
            .byp_en (byp_en),
            .we     (we),
            .wa     (wa),
            .wd     (wd),
            .rdata  (rdata[i*XLEN +: XLEN]),
            .rbusy  (rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expectations, a monitor pops and checks.

module tb_regfile_sb;
    logic         CLK = 1'b0;
    logic         nRST;
    logic [4:0]   rs0, rs1, wa0, wa1, issue_rd;
    logic [63:0]  wd0, wd1;
    logic [1:0]   we;
    logic         issue_valid, flush;
    logic [9:0]   rs_addr, waddr;
    logic [127:0] wdata;
    logic [127:0] rdata_b, rdata_n;
    logic [1:0]   rbusy_b, rbusy_n;
    logic         stall_b, stall_n;

    assign rs_addr = {rs1, rs0};
    assign waddr   = {wa1, wa0};
    assign wdata   = {wd1, wd0};

    always #5 CLK = ~CLK;

    regfile_sb #(.BYPASS(1)) u_dut (
        .CLK(CLK), .nRST(nRST), .rs_addr(rs_addr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_stall(stall_b), .flush(flush)
    );

    regfile_sb #(.BYPASS(0)) u_nb (
        .CLK(CLK), .nRST(nRST), .rs_addr(rs_addr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_stall(stall_n), .flush(flush)
    );

    typedef struct {
        string       nm;
        logic [63:0] rd0, rd1, nb0;
        logic [1:0]  rb;
        logic        st;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] rd0, input logic [63:0] rd1,
                       input logic [1:0] rb, input logic st, input logic [63:0] nb0);
        exp_t e;
        e.nm = nm; e.rd0 = rd0; e.rd1 = rd1; e.rb = rb; e.st = st; e.nb0 = nb0;
        q.push_back(e);
        -> chk_ev;
    endtask

    task automatic idle();
        we = 2'b00; issue_valid = 1'b0; flush = 1'b0;
    endtask

    // Monitor: outputs are combinational, so every expectation is sampled when posted.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.nm, "rdata0", rdata_b[63:0], e.rd0);
                cmp(e.nm, "rdata1", rdata_b[127:64], e.rd1);
                cmp(e.nm, "rbusy", {62'd0, rbusy_b}, {62'd0, e.rb});
                cmp(e.nm, "stall", {63'd0, stall_b}, {63'd0, e.st});
                cmp(e.nm, "nb_rdata0", rdata_n[63:0], e.nb0);
            end
        end
    end

    initial begin
        nRST = 1'b0;
        idle();
        rs0 = 5'd0; rs1 = 5'd0; wa0 = 5'd0; wa1 = 5'd0; wd0 = '0; wd1 = '0; issue_rd = 5'd0;

        // In reset: a write and an issue must not leak to outputs
        @(negedge CLK);
        we = 2'b01; wa0 = 5'd5; wd0 = 64'h1111; rs0 = 5'd5; rs1 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1 chk("reset", 64'h0, 64'h0, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle(); nRST = 1'b1;

        // Write x5, same-cycle read
        @(negedge CLK);
        we = 2'b01; wa0 = 5'd5; wd0 = 64'h1111; rs0 = 5'd5; rs1 = 5'd0;
        #1 chk("byp_x5", 64'h1111, 64'h0, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle();
        #1 chk("after_x5", 64'h1111, 64'h0, 2'b00, 1'b0, 64'h1111);

        // Dual write same address: port 1 wins
        @(negedge CLK);
        we = 2'b11; wa0 = 5'd7; wa1 = 5'd7; wd0 = 64'hAAAA; wd1 = 64'hBBBB; rs0 = 5'd7; rs1 = 5'd7;
        #1 chk("prio_byp", 64'hBBBB, 64'hBBBB, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle();
        #1 chk("prio_reg", 64'hBBBB, 64'hBBBB, 2'b00, 1'b0, 64'hBBBB);

        // x0 write and issue ignored
        @(negedge CLK);
        we = 2'b01; wa0 = 5'd0; wd0 = 64'hFFFF; issue_valid = 1'b1; issue_rd = 5'd0; rs0 = 5'd0; rs1 = 5'd0;
        #1 chk("x0_wr", 64'h0, 64'h0, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle();
        #1 chk("x0_after", 64'h0, 64'h0, 2'b00, 1'b0, 64'h0);

        // Issue rd=3, then re-issue stalls
        @(negedge CLK);
        issue_valid = 1'b1; issue_rd = 5'd3; rs0 = 5'd3; rs1 = 5'd5;
        #1 chk("issue3", 64'h0, 64'h1111, 2'b00, 1'b0, 64'h0);
        @(negedge CLK);
        #1 chk("waw3", 64'h0, 64'h1111, 2'b01, 1'b1, 64'h0);
        // Write x3 while re-issuing: stall holds, bypass hides busy
        @(negedge CLK);
        we = 2'b01; wa0 = 5'd3; wd0 = 64'h3333;
        #1 chk("wr3_stall", 64'h3333, 64'h1111, 2'b00, 1'b1, 64'h0);
        @(negedge CLK); idle();
        #1 chk("clr3", 64'h3333, 64'h1111, 2'b00, 1'b0, 64'h3333);

        // Issue and write x4 in the same cycle: set wins
        @(negedge CLK);
        issue_valid = 1'b1; issue_rd = 5'd4; we = 2'b01; wa0 = 5'd4; wd0 = 64'h4444; rs0 = 5'd4; rs1 = 5'd4;
        #1 chk("set_wr4", 64'h4444, 64'h4444, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle();
        #1 chk("busy4", 64'h4444, 64'h4444, 2'b11, 1'b0, 64'h4444);

        // Flush with issue rd=6 and a write to x8
        @(negedge CLK);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6; we = 2'b01; wa0 = 5'd8; wd0 = 64'h8888; rs1 = 5'd6;
        #1 chk("flush", 64'h4444, 64'h0, 2'b01, 1'b0, 64'h4444);
        @(negedge CLK); idle();
        #1 chk("post_flush", 64'h4444, 64'h0, 2'b00, 1'b0, 64'h4444);
        @(negedge CLK); rs0 = 5'd8; rs1 = 5'd3;
        #1 chk("flush_wr", 64'h8888, 64'h3333, 2'b00, 1'b0, 64'h8888);

        // Load x1..x31, mark x9 busy
        for (int i = 1; i < 32; i++) begin
            @(negedge CLK);
            we = 2'b01; wa0 = i[4:0]; wd0 = 64'h1000 + 64'(i);
        end
        @(negedge CLK); idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge CLK); idle(); rs0 = 5'd9; rs1 = 5'd31;
        #1 chk("loaded", 64'h1009, 64'h101F, 2'b01, 1'b0, 64'h1009);

        // Mid-cycle reset with a pending write and issue
        @(negedge CLK);
        we = 2'b01; wa0 = 5'd9; wd0 = 64'h9999; issue_valid = 1'b1; issue_rd = 5'd12;
        #1 chk("pre_rst", 64'h9999, 64'h101F, 2'b00, 1'b0, 64'h1009);
        #1 nRST = 1'b0;
        #1 chk("async_rst", 64'h0, 64'h0, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle(); nRST = 1'b1;
        #1 chk("rst_rel", 64'h0, 64'h0, 2'b00, 1'b0, 64'h0);
        @(negedge CLK);
        we = 2'b01; wa0 = 5'd9; wd0 = 64'h5A5A;
        #1 chk("first_wr", 64'h5A5A, 64'h0, 2'b00, 1'b0, 64'h0);
        @(negedge CLK); idle();
        #1 chk("first_upd", 64'h5A5A, 64'h0, 2'b00, 1'b0, 64'h5A5A);

        #20;
        if (q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
